// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared constants for the SD command-line engine
package sd_cmd_pkg;
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_48   = 2'b01;
    localparam logic [1:0] RESP_136  = 2'b10;
    typedef logic [2:0] state_t;
    localparam state_t IDLE       = 3'd0;
    localparam state_t SEND       = 3'd1;
    localparam state_t TURN       = 3'd2;
    localparam state_t WAIT_START = 3'd3;
    localparam state_t RECV       = 3'd4;
    localparam state_t GAP        = 3'd5;
    localparam int FRAME_48  = 48;
    localparam int FRAME_136 = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/sd_cmd_phy_if.sv
// sd_cmd_phy_if: register-file / CMD-line bundle of the SD command engine
interface sd_cmd_phy_if #(parameter int TO_W = 16);
    logic            start;
    logic [5:0]      cmd_index;
    logic [31:0]     argument;
    logic [1:0]      resp_type;
    logic [TO_W-1:0] timeout_limit;
    logic            cmd_in;
    logic            cmd_out;
    logic            cmd_oe;
    logic            busy;
    logic            cmd_complete;
    logic            cmd_index_error;
    logic            cmd_crc_error;
    logic            cmd_timeout_error;
    logic [127:0]    response;
    modport master (
        output start, cmd_index, argument, resp_type, timeout_limit, cmd_in,
        input  cmd_out, cmd_oe, busy, cmd_complete, cmd_index_error, cmd_crc_error,
               cmd_timeout_error, response
    );
    modport slave (
        input  start, cmd_index, argument, resp_type, timeout_limit, cmd_in,
        output cmd_out, cmd_oe, busy, cmd_complete, cmd_index_error, cmd_crc_error,
               cmd_timeout_error, response
    );
endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), one data bit per enabled cycle
module sd_crc7 import sd_cmd_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [6:0] crc
);
    always_ff @(posedge clk) begin
        if (reset || clr) crc <= '0;
        else if (en) crc <= {crc[5:0], 1'b0} ^ ((d ^ crc[6]) ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: serialises the 48-bit SD command frame and receives the card response
module sd_cmd_phy import sd_cmd_pkg::*; #(
    parameter int NCR_TURN = 2,
    parameter int NRC_GAP  = 8,
    parameter int TO_W     = 16
) (
    input logic         clk,
    input logic         reset,
    sd_cmd_phy_if.slave bus
);
    state_t          state;
    logic [7:0]      cnt;
    logic [TO_W-1:0] wcnt, tlim;
    logic [5:0]      idx;
    logic [39:0]     tx;
    logic [1:0]      rtype;
    logic [126:0]    rx;
    logic [127:0]    rx_n;
    logic [6:0]      tx_crc, rx_crc;
    logic [2:0]      crc_sel;
    logic            accept, last, cpl, idx_err, crc_err, to_err;
    logic [127:0]    resp;

    assign accept = state == IDLE && !cpl && bus.start;
    assign rx_n   = {rx, bus.cmd_in};
    assign last   = state == RECV && cnt == (rtype == RESP_136 ? 8'(FRAME_136 - 2) : 8'(FRAME_48 - 2));

    sd_crc7 u_tx_crc (
        .clk(clk), .reset(reset), .clr(accept),
        .en(state == SEND && cnt < 8'd40), .d(tx[39]), .crc(tx_crc)
    );
    // Receive CRC covers the start bit seen in WAIT_START plus 39 bits in RECV.
    sd_crc7 u_rx_crc (
        .clk(clk), .reset(reset), .clr(accept),
        .en((state == WAIT_START && !bus.cmd_in) || (state == RECV && cnt < 8'd39)),
        .d(bus.cmd_in), .crc(rx_crc)
    );

    always_comb begin
        crc_sel = 3'(8'd46 - cnt);
        bus.cmd_out = (state != SEND) ? 1'b1 : (cnt < 8'd40) ? tx[39] : (cnt == 8'd47) ? 1'b1 : tx_crc[crc_sel];
    end

    assign bus.cmd_oe            = state == SEND;
    assign bus.busy              = state != IDLE || cpl;
    assign bus.cmd_complete      = cpl;
    assign bus.cmd_index_error   = idx_err;
    assign bus.cmd_crc_error     = crc_err;
    assign bus.cmd_timeout_error = to_err;
    assign bus.response          = resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wcnt    <= '0;
            cpl     <= 1'b0;
            idx_err <= 1'b0;
            crc_err <= 1'b0;
            to_err  <= 1'b0;
            resp    <= '0;
        end else begin
            cpl <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    idx     <= bus.cmd_index;
                    tx      <= {2'b01, bus.cmd_index, bus.argument};
                    rtype   <= bus.resp_type == 2'b11 ? RESP_NONE : bus.resp_type;
                    tlim    <= bus.timeout_limit;
                    idx_err <= 1'b0;
                    crc_err <= 1'b0;
                    to_err  <= 1'b0;
                    cnt     <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    cnt <= cnt + 8'd1;
                    tx  <= {tx[38:0], 1'b0};
                    if (cnt == 8'(FRAME_48 - 1)) begin
                        cnt   <= '0;
                        state <= rtype == RESP_NONE ? GAP : TURN;
                    end
                end
                TURN: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(NCR_TURN - 1)) begin
                        cnt   <= '0;
                        wcnt  <= '0;
                        state <= WAIT_START;
                    end
                end
                // The start bit wins over a timeout landing in the same cycle.
                WAIT_START: begin
                    if (!bus.cmd_in) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else if (wcnt == tlim) begin
                        to_err <= 1'b1;
                        cnt    <= '0;
                        state  <= GAP;
                    end else begin
                        wcnt <= wcnt + TO_W'(1);
                    end
                end
                RECV: begin
                    rx  <= rx_n[126:0];
                    cnt <= cnt + 8'd1;
                    if (last) begin
                        if (rtype == RESP_136) begin
                            resp <= {8'h00, rx_n[127:8]};
                        end else begin
                            resp    <= {96'h0, rx_n[39:8]};
                            idx_err <= rx_n[45:40] != idx;
                            crc_err <= rx_n[7:1] != rx_crc || !rx_n[0];
                        end
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(NRC_GAP - 1)) begin
                        cnt   <= '0;
                        cpl   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: directed bench with a per-cycle timeline model of the CMD engine
module tb_sd_cmd_phy;
    import sd_cmd_pkg::*;

    typedef struct packed {logic oe; logic out; logic busy; logic cpl;} exp_t;
    localparam exp_t E_IDLE = 4'b0100;
    localparam exp_t E_BUSY = 4'b0110;
    localparam exp_t E_CPL  = 4'b0111;
    localparam logic [119:0] PAY = 120'h0123456789ABCDEF0123456789ABEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sd_cmd_phy_if #(.TO_W(16)) bus();
    sd_cmd_phy #(.NCR_TURN(2), .NRC_GAP(8), .TO_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [47:0] cap;
    logic [127:0] model_resp;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] mcrc(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, mcrc(m), 1'b1};
    endfunction

    function automatic logic [135:0] r1(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {88'h0, m, mcrc(m), 1'b1};
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (bus.cmd_oe) cap <= {cap[46:0], bus.cmd_out};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmd_oe", 128'(bus.cmd_oe), 128'(e.oe));
            chk("cmd_out", 128'(bus.cmd_out), 128'(e.out));
            chk("busy", 128'(bus.busy), 128'(e.busy));
            chk("cmd_complete", 128'(bus.cmd_complete), 128'(e.cpl));
        end
    end

    task automatic step(input logic st, input exp_t e, input logic din);
        bus.start = st;
        bus.cmd_in = din;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // delay < 0: card never answers; reset_at >= 0: reset during that SEND bit
    task automatic xact(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [1:0] rt, input logic [15:0] tlim, input int delay,
                        input logic [135:0] reply, input int reset_at, input bit stray);
        logic [47:0] f = frame(idx, arg);
        bit r = (rt == RESP_48) || (rt == RESP_136);
        int rlen = (rt == RESP_136) ? FRAME_136 : FRAME_48;
        bit got_reply = r && delay >= 0;
        bit e_idx = got_reply && rt == RESP_48 && reply[45:40] != idx;
        bit e_crc = got_reply && rt == RESP_48 && (reply[7:1] != mcrc(reply[47:8]) || !reply[0]);
        bit e_to = r && delay < 0;
        bus.cmd_index = idx;
        bus.argument = arg;
        bus.resp_type = rt;
        bus.timeout_limit = tlim;
        step(1'b1, E_IDLE, 1'b1);
        for (int i = 0; i < 48; i++) begin
            if (i == 1)
                chk({tag, " err_clr"}, 128'({bus.cmd_index_error, bus.cmd_crc_error, bus.cmd_timeout_error}), 128'(0));
            if (stray && i == 10) begin
                bus.cmd_index = 6'h3F;
                bus.argument = 32'hFFFF_FFFF;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                step(1'b0, {1'b1, f[47-i], 2'b10}, 1'b1);
                reset = 1'b0;
                model_resp = '0;
                step(1'b0, E_IDLE, 1'b1);
                chk({tag, " rst_flags"}, 128'({bus.cmd_index_error, bus.cmd_crc_error, bus.cmd_timeout_error}), 128'(0));
                chk({tag, " rst_resp"}, bus.response, model_resp);
                return;
            end
            step(stray && i == 10, {1'b1, f[47-i], 2'b10}, 1'b1);
        end
        if (r) begin
            repeat (2) step(1'b0, E_BUSY, 1'b1);
            if (delay < 0) begin
                repeat (int'(tlim) + 1) step(1'b0, E_BUSY, 1'b1);
            end else begin
                repeat (delay) step(1'b0, E_BUSY, 1'b1);
                for (int j = rlen - 1; j >= 0; j--) step(1'b0, E_BUSY, reply[j]);
            end
        end
        repeat (8) step(1'b0, E_BUSY, 1'b1);
        step(1'b0, E_CPL, 1'b1);
        step(1'b0, E_IDLE, 1'b1);
        if (got_reply) model_resp = (rt == RESP_136) ? {8'h00, reply[127:8]} : {96'h0, reply[39:8]};
        chk({tag, " frame"}, 128'(cap), 128'(f));
        chk({tag, " idx_err"}, 128'(bus.cmd_index_error), 128'(e_idx));
        chk({tag, " crc_err"}, 128'(bus.cmd_crc_error), 128'(e_crc));
        chk({tag, " to_err"}, 128'(bus.cmd_timeout_error), 128'(e_to));
        chk({tag, " response"}, bus.response, model_resp);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cmd_index = '0;
        bus.argument = '0;
        bus.resp_type = RESP_NONE;
        bus.timeout_limit = '0;
        bus.cmd_in = 1'b1;
        model_resp = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset cmd_out", 128'(bus.cmd_out), 128'(1));
        chk("reset cmd_oe", 128'(bus.cmd_oe), 128'(0));
        chk("reset busy", 128'(bus.busy), 128'(0));
        chk("reset cmd_complete", 128'(bus.cmd_complete), 128'(0));
        chk("reset flags", 128'({bus.cmd_index_error, bus.cmd_crc_error, bus.cmd_timeout_error}), 128'(0));
        chk("reset response", bus.response, 128'(0));

        xact("cmd0", 6'd0, 32'h0, RESP_NONE, 16'd16, 0, '0, -1, 1'b0);
        chk("cmd0 literal frame", 128'(cap), 128'(48'h40_00000000_95));

        xact("cmd8", 6'd8, 32'h1AA, RESP_48, 16'd100, 3, r1(6'h08, 32'h1AA), -1, 1'b1);
        chk("cmd8 literal frame", 128'(cap), 128'(48'h48_000001AA_87));
        chk("cmd8 literal response", bus.response, 128'h1AA);

        xact("cmd17", 6'd17, 32'h0, RESP_48, 16'd100, 0, r1(6'h12, 32'h900), -1, 1'b0);
        chk("cmd17 literal frame", 128'(cap), 128'(48'h51_00000000_55));
        chk("cmd17 literal idx_err", 128'(bus.cmd_index_error), 128'(1));

        xact("cmd2", 6'd2, 32'h0, RESP_136, 16'd100, 5, {2'b00, 6'h3F, PAY, 8'h01}, -1, 1'b0);
        chk("cmd2 literal frame", 128'(cap), 128'(48'h42_00000000_4D));
        chk("cmd2 literal response", bus.response, {8'h00, PAY});

        xact("cmd13_to", 6'd13, 32'h10000, RESP_48, 16'd16, -1, '0, -1, 1'b0);
        chk("cmd13 literal timeout", 128'(bus.cmd_timeout_error), 128'(1));

        xact("cmd13_crc", 6'd13, 32'h10000, RESP_48, 16'd16, 2, r1(6'd13, 32'h900) ^ 136'h8, -1, 1'b0);
        chk("cmd13 literal crc_err", 128'(bus.cmd_crc_error), 128'(1));

        xact("endbit", 6'd13, 32'h10000, RESP_48, 16'd16, 16, r1(6'd13, 32'h77) ^ 136'h1, -1, 1'b0);
        xact("tlim0_hit", 6'd55, 32'h0, RESP_48, 16'd0, 0, r1(6'd55, 32'h5), -1, 1'b0);
        xact("tlim0_to", 6'd55, 32'h0, RESP_48, 16'd0, -1, '0, -1, 1'b0);
        xact("rsv", 6'd0, 32'hA5, 2'b11, 16'd16, 0, '0, -1, 1'b0);
        xact("reset", 6'd8, 32'h1AA, RESP_48, 16'd100, 3, r1(6'h08, 32'h1AA), 20, 1'b0);
        xact("after_reset", 6'd0, 32'h0, RESP_NONE, 16'd16, 0, '0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
- Command-line engine downstream of the SD host register file.
- Takes the command index, argument and response type decoded from the Command/Argument/Transfer_Mode registers, serialises the 48-bit SD command frame with CRC7 onto the CMD line, and receives the card response.
- Reports cmd_complete, cmd_index_error, CRC and timeout status, plus the response words, back into the register file (Response0..7 and register 25 status bits).
- Transfers one CMD-line bit per clk cycle.

Parameters:
- NCR_TURN, 2, cycles the CMD line is released between the command end bit and the start of response sampling.
- NRC_GAP, 8, idle cycles enforced after the response or command before a new command is accepted.
- TO_W, 16, width of the response timeout counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to issue a command; sampled only while busy=0.
- cmd_index  in  6  command index (Command[13:8]).
- argument  in  32  command argument.
- resp_type  in  2  00 none, 01 48-bit (R1/R3/R6/R7), 10 136-bit (R2), 11 reserved (treated as 00).
- timeout_limit  in  TO_W  maximum wait cycles for the response start bit.
- cmd_in  in  1  sampled CMD line.
- cmd_out  out  1  driven CMD bit.
- cmd_oe  out  1  CMD output enable.
- busy  out  1  high from the accepted start until return to IDLE.
- cmd_complete  out  1  one-cycle pulse at the end of the transaction.
- cmd_index_error  out  1  sticky until the next accepted start.
- cmd_crc_error  out  1  sticky until the next accepted start.
- cmd_timeout_error  out  1  sticky until the next accepted start.
- response  out  128  captured response payload.

Behaviour:
- Reset values: cmd_out=1, cmd_oe=0, busy=0, all error flags=0, cmd_complete=0, response=0, state=IDLE.
- Reset mid-operation aborts immediately; the next cycle sees IDLE with the line released.
- IDLE: on start=1, latch cmd_index, argument, resp_type and timeout_limit. Clear all errors and the CRC. Go to SEND with busy=1 the next cycle.
- SEND: 48 cycles, MSB first, cmd_oe=1.
  - Frame: 0 (start), 1 (transmission), cmd_index[5:0], argument[31:0], CRC7[6:0], 1 (end).
  - CRC7 polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8.
- After SEND: if resp_type is none, go to GAP. Otherwise go to TURN.
- TURN: NCR_TURN cycles with cmd_oe=0 and cmd_out=1.
- WAIT_START: count cycles while cmd_in=1.
  - cmd_in=0 means start bit seen; go to RECV.
  - Counter reaching timeout_limit sets cmd_timeout_error and goes to GAP.
  - timeout_limit=0 times out on the first WAIT_START cycle unless cmd_in=0 in that cycle; the start bit wins.
- RECV: shift in the remaining 47 (R1) or 135 (R2) bits.
  - R1: response[31:0] = bits 39:8, response[127:32] = 0.
    - Index check: bits 45:40 != latched index sets cmd_index_error.
    - CRC check over bits 47:8 against bits 7:1; mismatch sets cmd_crc_error.
    - End bit 0 also sets cmd_crc_error.
  - R2: response[119:0] = bits 127:8, response[127:120] = 0. No index or CRC check.
- GAP: NRC_GAP cycles with cmd_oe=0. On exit, pulse cmd_complete for one cycle (also on error or timeout), then IDLE with busy=0 the cycle after.
- start while busy=1 is ignored with no side effects.

Decomposition:
- Shared package sd_cmd_pkg:
  - resp_type constants (RESP_NONE, RESP_48, RESP_136).
  - State encoding (IDLE, SEND, TURN, WAIT_START, RECV, GAP).
  - Frame lengths (48, 136) and CRC7 polynomial constant.
- Sub-module sd_crc7: serial CRC7 with clear, enable and data-bit inputs and a 7-bit output. It is instantiated twice, for transmit and receive.

Test Plan:
- CMD0, arg 0, resp none → cmd_out stream 0x40_00000000_95 over 48 cycles. No response sampling occurs. cmd_complete pulses NRC_GAP cycles after the end bit; no errors.
- CMD8, arg 0x000001AA, R1; bench returns 0x08_000001AA with correct CRC → frame sent 0x48_000001AA_87. response=0x000001AA; no errors.
- CMD17, arg 0, R1; bench replies with index 0x12 and valid CRC → frame 0x51_00000000_55. cmd_index_error=1, cmd_crc_error=0, cmd_complete pulses.
- CMD2, R2; bench returns 136 bits with payload 0x0123…EF (120 bits) → response[119:0] matches the payload, response[127:120]=0, no errors.
- R1 with timeout_limit=16 and cmd_in held at 1 → cmd_timeout_error=1 after 16 WAIT_START cycles, cmd_complete pulses after GAP. Repeat with a corrupted CRC bit → cmd_crc_error=1.
- Reset asserted at SEND bit 20 → next cycle cmd_oe=0, cmd_out=1, busy=0. A start pulse while busy is ignored, and the in-flight frame is unchanged.
